video_layer_mixer: RTL and testbench

- Pixel-rate compositor directly downstream of the tilemap layer.
- Merges sprite, character, tilemap and starfield layers plus a CPU-set background colour into one RGB888 stream, with a 2-stage registered pipeline.
- Applies a CPU-controlled frame-based brightness fade.
- Sits between the layer generators and the video output/scandoubler path.

---
 rtl/video_layer_mixer_if.sv | 10 +
 rtl/video_layer_mixer.sv | 176 +++++++++++++++++
 tb/tb_video_layer_mixer.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/video_layer_mixer_if.sv
// CPU register bus for the video layer mixer: address, write data/strobe, read data.
interface video_layer_mixer_if;
  logic [2:0] addr;
  logic [7:0] data_in;
  logic       write;
  logic [7:0] data_out;

  modport master (output addr, output data_in, output write, input data_out);
  modport slave  (input addr, input data_in, input write, output data_out);
endinterface

// File: rtl/video_layer_mixer.sv
// Pixel-rate layer compositor with a 2-stage pipeline and a frame-based brightness fade.
module video_layer_mixer #(
  parameter logic [4:0]  FADE_MAX     = 5'd16,
  parameter logic [23:0] BLANK_COLOUR = 24'h000000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                pix_ce,
  input  logic                hblank,
  input  logic                vblank,
  input  logic [7:0]          spr_r,
  input  logic [7:0]          spr_g,
  input  logic [7:0]          spr_b,
  input  logic                spr_a,
  input  logic [7:0]          chr_r,
  input  logic [7:0]          chr_g,
  input  logic [7:0]          chr_b,
  input  logic                chr_a,
  input  logic [7:0]          tm_r,
  input  logic [7:0]          tm_g,
  input  logic [7:0]          tm_b,
  input  logic                tm_a,
  input  logic [7:0]          star_r,
  input  logic [7:0]          star_g,
  input  logic [7:0]          star_b,
  video_layer_mixer_if.slave  cpu,
  output logic [7:0]          out_r,
  output logic [7:0]          out_g,
  output logic [7:0]          out_b,
  output logic                out_hblank,
  output logic                out_vblank
);

  localparam int unsigned CW = 8;
  localparam int unsigned LW = 5;
  localparam int unsigned PW = 13;
  localparam int unsigned RGBW = 3 * CW;

  logic [4:0]      ctrl;
  logic [CW-1:0]   bg_r, bg_g, bg_b;
  logic [LW-1:0]   fade_target;
  logic [7:0]      fade_period;
  logic [LW-1:0]   level;
  logic [7:0]      frame_cnt;
  logic            vblank_q;
  logic            vblank_rise;
  logic            fade_busy;

  logic            tm_on, spr_on, chr_on, star_on;
  logic [RGBW-1:0] sel_rgb;
  logic [RGBW-1:0] s1_rgb;
  logic            s1_hblank, s1_vblank;

  // Scale one colour component by level/16; level 16 returns c unchanged.
  function automatic logic [CW-1:0] scale(input logic [CW-1:0] c, input logic [LW-1:0] lvl);
    logic [PW-1:0] p;
    p = PW'(c) * PW'(lvl);
    return CW'(p >> 4);
  endfunction

  assign vblank_rise = vblank & ~vblank_q;
  assign fade_busy   = (level != fade_target);

  // CPU-writable registers; fade target clamps to full brightness.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl        <= 5'h0F;
      bg_r        <= '0;
      bg_g        <= '0;
      bg_b        <= '0;
      fade_target <= FADE_MAX;
      fade_period <= '0;
    end else if (cpu.write) begin
      case (cpu.addr)
        3'd0: ctrl <= cpu.data_in[4:0];
        3'd1: bg_r <= cpu.data_in;
        3'd2: bg_g <= cpu.data_in;
        3'd3: bg_b <= cpu.data_in;
        3'd4: fade_target <= (cpu.data_in > 8'(FADE_MAX)) ? FADE_MAX : cpu.data_in[4:0];
        3'd5: fade_period <= cpu.data_in;
        default: ;
      endcase
    end
  end

  // Fade engine: one evaluation per vblank rising edge, using the target held before any same-cycle write.
  always_ff @(posedge clk) begin
    if (reset) begin
      vblank_q  <= 1'b0;
      level     <= FADE_MAX;
      frame_cnt <= '0;
    end else begin
      vblank_q <= vblank;
      if (vblank_rise) begin
        if (!fade_busy) begin
          frame_cnt <= '0;
        end else if (frame_cnt >= fade_period) begin
          frame_cnt <= '0;
          level     <= (level < fade_target) ? level + LW'(1) : level - LW'(1);
        end else begin
          frame_cnt <= frame_cnt + 8'd1;
        end
      end
    end
  end

  // Register read mux.
  always_comb begin
    cpu.data_out = '0;
    case (cpu.addr)
      3'd0: cpu.data_out = {3'b000, ctrl};
      3'd1: cpu.data_out = bg_r;
      3'd2: cpu.data_out = bg_g;
      3'd3: cpu.data_out = bg_b;
      3'd4: cpu.data_out = {3'b000, fade_target};
      3'd5: cpu.data_out = fade_period;
      3'd6: cpu.data_out = {2'b00, level, fade_busy};
      default: cpu.data_out = '0;
    endcase
  end

  // Layer priority select; ctrl[4] moves sprites behind the tilemap.
  always_comb begin
    tm_on   = ctrl[0] & tm_a;
    spr_on  = ctrl[1] & spr_a;
    chr_on  = ctrl[2] & chr_a;
    star_on = ctrl[3] & (|{star_r, star_g, star_b});
    sel_rgb = {bg_r, bg_g, bg_b};
    if (ctrl[4]) begin
      if (chr_on)       sel_rgb = {chr_r, chr_g, chr_b};
      else if (tm_on)   sel_rgb = {tm_r, tm_g, tm_b};
      else if (spr_on)  sel_rgb = {spr_r, spr_g, spr_b};
      else if (star_on) sel_rgb = {star_r, star_g, star_b};
    end else begin
      if (spr_on)       sel_rgb = {spr_r, spr_g, spr_b};
      else if (chr_on)  sel_rgb = {chr_r, chr_g, chr_b};
      else if (tm_on)   sel_rgb = {tm_r, tm_g, tm_b};
      else if (star_on) sel_rgb = {star_r, star_g, star_b};
    end
  end

  // Stage 1: capture selected colour and blanks.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_rgb    <= '0;
      s1_hblank <= 1'b0;
      s1_vblank <= 1'b0;
    end else if (pix_ce) begin
      s1_rgb    <= sel_rgb;
      s1_hblank <= hblank;
      s1_vblank <= vblank;
    end
  end

  // Stage 2: apply fade or force blank colour, register outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_r      <= '0;
      out_g      <= '0;
      out_b      <= '0;
      out_hblank <= 1'b1;
      out_vblank <= 1'b1;
    end else if (pix_ce) begin
      if (s1_hblank | s1_vblank) begin
        {out_r, out_g, out_b} <= BLANK_COLOUR;
      end else begin
        out_r <= scale(s1_rgb[23:16], level);
        out_g <= scale(s1_rgb[15:8], level);
        out_b <= scale(s1_rgb[7:0], level);
      end
      out_hblank <= s1_hblank;
      out_vblank <= s1_vblank;
    end
  end

endmodule

// File: tb/tb_video_layer_mixer.sv
// Directed bench for video_layer_mixer: priority table, pipeline latency, fade engine, reset.
module tb_video_layer_mixer;

  logic       clk;
  logic       reset;
  logic       pix_ce;
  logic       hblank, vblank;
  logic [7:0] spr_r, spr_g, spr_b, chr_r, chr_g, chr_b, tm_r, tm_g, tm_b;
  logic [7:0] star_r, star_g, star_b;
  logic       spr_a, chr_a, tm_a;
  logic [7:0] out_r, out_g, out_b;
  logic       out_hblank, out_vblank;

  video_layer_mixer_if cpu_if ();

  video_layer_mixer dut (
    .clk(clk), .reset(reset), .pix_ce(pix_ce), .hblank(hblank), .vblank(vblank),
    .spr_r(spr_r), .spr_g(spr_g), .spr_b(spr_b), .spr_a(spr_a),
    .chr_r(chr_r), .chr_g(chr_g), .chr_b(chr_b), .chr_a(chr_a),
    .tm_r(tm_r), .tm_g(tm_g), .tm_b(tm_b), .tm_a(tm_a),
    .star_r(star_r), .star_g(star_g), .star_b(star_b),
    .cpu(cpu_if),
    .out_r(out_r), .out_g(out_g), .out_b(out_b),
    .out_hblank(out_hblank), .out_vblank(out_vblank)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  ctrl;
    logic [23:0] spr;
    logic        spr_a;
    logic [23:0] chr;
    logic        chr_a;
    logic [23:0] tm;
    logic        tm_a;
    logic [23:0] star;
    logic [23:0] bg;
    logic        hb;
    logic [23:0] exp_rgb;
    logic        exp_hb;
  } vec_t;

  localparam int NVEC = 12;
  vec_t vecs[NVEC];

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic [2:0] a, input logic [7:0] d);
    cpu_if.addr = a; cpu_if.data_in = d; cpu_if.write = 1'b1;
    tick();
    cpu_if.write = 1'b0;
  endtask

  task automatic cpu_read(input logic [2:0] a, output logic [7:0] d);
    cpu_if.addr = a;
    #1;
    d = cpu_if.data_out;
  endtask

  task automatic pix();
    pix_ce = 1'b1;
    tick();
    pix_ce = 1'b0;
  endtask

  task automatic vpulse();
    vblank = 1'b1;
    tick();
    vblank = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic set_layers(input logic [23:0] s, input logic sa, input logic [23:0] c, input logic ca,
                            input logic [23:0] t, input logic ta, input logic [23:0] st);
    {spr_r, spr_g, spr_b} = s;  spr_a = sa;
    {chr_r, chr_g, chr_b} = c;  chr_a = ca;
    {tm_r, tm_g, tm_b} = t;     tm_a = ta;
    {star_r, star_g, star_b} = st;
  endtask

  task automatic check_level(input string name, input int lvl, input int tgt);
    logic [7:0] d;
    cpu_read(3'd6, d);
    check(name, 32'(d), 32'((lvl << 1) | ((lvl != tgt) ? 1 : 0)));
  endtask

  function automatic vec_t mk(input logic [7:0] ctrl, input logic [23:0] spr, input logic spa,
                              input logic [23:0] chr, input logic cha, input logic [23:0] tm,
                              input logic tma, input logic [23:0] star, input logic [23:0] bg,
                              input logic hb, input logic [23:0] er, input logic eh);
    vec_t v;
    v.ctrl = ctrl; v.spr = spr; v.spr_a = spa; v.chr = chr; v.chr_a = cha;
    v.tm = tm; v.tm_a = tma; v.star = star; v.bg = bg; v.hb = hb;
    v.exp_rgb = er; v.exp_hb = eh;
    return v;
  endfunction

  initial begin
    logic [7:0] d;

    vecs[0]  = mk(8'h0F, 24'h112233, 1, 24'h445566, 1, 24'h778899, 1, 24'h000000, 24'h000000, 0, 24'h112233, 0);
    vecs[1]  = mk(8'h1F, 24'h112233, 1, 24'h445566, 1, 24'h778899, 1, 24'h000000, 24'h000000, 0, 24'h445566, 0);
    vecs[2]  = mk(8'h1C, 24'h112233, 1, 24'h445566, 1, 24'h778899, 1, 24'h000000, 24'h000000, 0, 24'h445566, 0);
    vecs[3]  = mk(8'h1A, 24'h112233, 1, 24'h445566, 1, 24'h778899, 1, 24'h000000, 24'h000000, 0, 24'h112233, 0);
    vecs[4]  = mk(8'h18, 24'h112233, 1, 24'h445566, 1, 24'h778899, 1, 24'h0A0B0C, 24'h000000, 0, 24'h0A0B0C, 0);
    vecs[5]  = mk(8'h0F, 24'h112233, 0, 24'h445566, 0, 24'h778899, 0, 24'h000000, 24'h102030, 0, 24'h102030, 0);
    vecs[6]  = mk(8'h0F, 24'h112233, 0, 24'h445566, 0, 24'h778899, 0, 24'h000100, 24'h102030, 0, 24'h000100, 0);
    vecs[7]  = mk(8'h07, 24'h112233, 0, 24'h445566, 0, 24'h778899, 0, 24'h0A0B0C, 24'h102030, 0, 24'h102030, 0);
    vecs[8]  = mk(8'h0F, 24'h112233, 0, 24'h445566, 1, 24'h778899, 1, 24'h0A0B0C, 24'h102030, 0, 24'h445566, 0);
    vecs[9]  = mk(8'h1F, 24'h112233, 1, 24'h445566, 0, 24'h778899, 0, 24'h0A0B0C, 24'h102030, 0, 24'h112233, 0);
    vecs[10] = mk(8'h1F, 24'h112233, 1, 24'h445566, 0, 24'h778899, 1, 24'h0A0B0C, 24'h102030, 0, 24'h778899, 0);
    vecs[11] = mk(8'h0F, 24'h112233, 0, 24'h445566, 0, 24'h778899, 0, 24'h000000, 24'h102030, 1, 24'h000000, 1);

    reset = 1'b1; pix_ce = 1'b0; hblank = 1'b0; vblank = 1'b0;
    cpu_if.addr = 3'd0; cpu_if.data_in = 8'h00; cpu_if.write = 1'b0;
    set_layers(24'h0, 0, 24'h0, 0, 24'h0, 0, 24'h0);
    tick(); tick();
    reset = 1'b0;

    // Reset state
    check("reset_rgb", 32'({out_r, out_g, out_b}), 32'h0);
    check("reset_hblank", 32'(out_hblank), 32'd1);
    check("reset_vblank", 32'(out_vblank), 32'd1);
    cpu_read(3'd0, d); check("reset_ctrl", 32'(d), 32'h0F);
    cpu_read(3'd4, d); check("reset_target", 32'(d), 32'd16);
    cpu_read(3'd6, d); check("reset_status", 32'(d), 32'h20);
    cpu_read(3'd7, d); check("r7_zero", 32'(d), 32'h00);

    // Priority / enable table
    for (int i = 0; i < NVEC; i++) begin
      cpu_write(3'd0, vecs[i].ctrl);
      cpu_write(3'd1, vecs[i].bg[23:16]);
      cpu_write(3'd2, vecs[i].bg[15:8]);
      cpu_write(3'd3, vecs[i].bg[7:0]);
      set_layers(vecs[i].spr, vecs[i].spr_a, vecs[i].chr, vecs[i].chr_a,
                 vecs[i].tm, vecs[i].tm_a, vecs[i].star);
      hblank = vecs[i].hb;
      pix(); pix();
      check($sformatf("vec%0d_rgb", i), 32'({out_r, out_g, out_b}), 32'(vecs[i].exp_rgb));
      check($sformatf("vec%0d_hblank", i), 32'(out_hblank), 32'(vecs[i].exp_hb));
    end
    hblank = 1'b0;

    // Blank latency is exactly two pix_ce pulses
    pix(); pix();
    check("lat_base", 32'({out_r, out_g, out_b}), 32'h102030);
    hblank = 1'b1;
    pix();
    check("lat_hb_1", 32'(out_hblank), 32'd0);
    check("lat_rgb_1", 32'({out_r, out_g, out_b}), 32'h102030);
    pix();
    check("lat_hb_2", 32'(out_hblank), 32'd1);
    check("lat_rgb_2", 32'({out_r, out_g, out_b}), 32'h0);
    hblank = 1'b0;
    vblank = 1'b1;
    pix(); pix();
    check("lat_vb", 32'(out_vblank), 32'd1);
    vblank = 1'b0;
    pix(); pix();
    check("lat_vb_clear", 32'(out_vblank), 32'd0);

    // Fade down at one step per frame
    cpu_write(3'd0, 8'h0F);
    cpu_write(3'd1, 8'h00); cpu_write(3'd2, 8'h00); cpu_write(3'd3, 8'h00);
    set_layers(24'h0, 0, 24'h0, 0, 24'hFF8010, 1, 24'h0);
    cpu_write(3'd5, 8'd0);
    cpu_write(3'd4, 8'd0);
    check_level("fade_start", 16, 0);
    for (int i = 1; i <= 16; i++) begin
      vpulse();
      check_level($sformatf("fade_dn%0d", i), 16 - i, 0);
      if (i == 8) begin
        pix(); pix();
        check("fade_half_rgb", 32'({out_r, out_g, out_b}), 32'h7F4008);
      end
    end
    pix(); pix();
    check("fade_zero_rgb", 32'({out_r, out_g, out_b}), 32'h0);
    vpulse();
    check_level("fade_floor", 0, 0);
    cpu_write(3'd4, 8'd40);
    cpu_read(3'd4, d); check("target_clamp", 32'(d), 32'd16);
    vpulse();
    check_level("fade_up1", 1, 16);

    // Slow fade: period 2 means a step every third frame
    do_reset();
    cpu_write(3'd5, 8'd2);
    cpu_write(3'd4, 8'd8);
    for (int i = 1; i <= 24; i++) begin
      vpulse();
      check_level($sformatf("slow%0d", i), 16 - i / 3, 8);
    end
    cpu_write(3'd4, 8'd0);
    for (int i = 0; i < 6; i++) vpulse();
    check_level("slow_to6", 6, 0);
    vpulse();
    check_level("slow_cnt1", 6, 0);
    cpu_write(3'd4, 8'd40);
    cpu_read(3'd4, d); check("retarget_clamp", 32'(d), 32'd16);
    vpulse();
    check_level("retarget_hold", 6, 16);
    vpulse();
    check_level("retarget_up", 7, 16);

    // Write to R4 on the same cycle as the vblank edge: step uses the old target
    cpu_write(3'd5, 8'd0);
    cpu_if.addr = 3'd4; cpu_if.data_in = 8'd0; cpu_if.write = 1'b1; vblank = 1'b1;
    tick();
    cpu_if.write = 1'b0; vblank = 1'b0;
    tick();
    check_level("same_cycle_old", 8, 0);
    vpulse();
    check_level("same_cycle_new", 7, 0);

    // pix_ce low holds every pipeline register
    do_reset();
    set_layers(24'h112233, 1, 24'h0, 0, 24'h0, 0, 24'h0);
    pix(); pix();
    check("hold_base", 32'({out_r, out_g, out_b}), 32'h112233);
    for (int i = 0; i < 5; i++) begin
      set_layers(24'($urandom), 1, 24'($urandom), 1, 24'($urandom), 1, 24'($urandom));
      hblank = ~hblank;
      tick();
      check($sformatf("hold%0d_rgb", i), 32'({out_r, out_g, out_b}), 32'h112233);
      check($sformatf("hold%0d_hb", i), 32'(out_hblank), 32'd0);
    end
    hblank = 1'b0;

    // Reset in the middle of a fade
    cpu_write(3'd4, 8'd5);
    for (int i = 0; i < 11; i++) vpulse();
    check_level("pre_reset_lvl5", 5, 5);
    cpu_write(3'd0, 8'h03);
    do_reset();
    check_level("post_reset_lvl", 16, 16);
    cpu_read(3'd0, d); check("post_reset_ctrl", 32'(d), 32'h0F);
    cpu_read(3'd4, d); check("post_reset_target", 32'(d), 32'd16);
    check("post_reset_rgb", 32'({out_r, out_g, out_b}), 32'h0);
    check("post_reset_hb", 32'(out_hblank), 32'd1);
    check("post_reset_vb", 32'(out_vblank), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
